// File: rtl/vga_fb_reader_pkg.sv
// Shared constants and types for the framebuffer reader: VGA counter width,
// RGB888 colour constants and the delay-line tap record.
package vga_fb_reader_pkg;

   localparam int unsigned VGA_CNT_W     = 11;
   localparam int unsigned RGB_W         = 24;
   localparam int unsigned H_VISIBLE_DEF = 800;
   localparam int unsigned V_VISIBLE_DEF = 480;

   localparam logic [RGB_W-1:0] RGB_BLACK = 24'h000000;
   localparam logic [RGB_W-1:0] RGB_WHITE = 24'hFFFFFF;

   typedef logic [RGB_W-1:0] rgb_t;

   // Sideband travelling alongside the RAM access
   typedef struct packed {
      logic       vis;
      logic [4:0] bit_idx;
   } tap_t;

   // LSB position of pixel k inside a word; pixel 0 sits in the MSBs
   function automatic logic [4:0] field_lsb(input int unsigned word_w,
                                            input int unsigned bpp,
                                            input int unsigned k);
      return 5'(word_w - bpp - k * bpp);
   endfunction

endpackage

// File: rtl/vga_fb_reader_palette.sv
// Palette RAM: 2^IDX_W x RGB888, synchronous read, a read colliding with a
// write returns the old entry. Contents survive reset; only the read register clears.
module vga_fb_reader_palette
   import vga_fb_reader_pkg::*;
#(
   parameter int unsigned IDX_W = 1
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [RGB_W-1:0] wdata_i,
   input  logic             rd_en_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [RGB_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << IDX_W;

   // Entry 0 black, everything else white, so a 1bpp frame shows unloaded
   function automatic logic [DEPTH-1:0][RGB_W-1:0] init_contents();
      logic [DEPTH-1:0][RGB_W-1:0] c;
      for (int i = 0; i < int'(DEPTH); i++) begin
         c[i] = (i == 0) ? RGB_BLACK : RGB_WHITE;
      end
      return c;
   endfunction

   logic [DEPTH-1:0][RGB_W-1:0] mem_q = init_contents();
   logic [RGB_W-1:0]            rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Blanked samples read as black so the output never smears
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rd_en_i ? mem_q[raddr_i] : RGB_BLACK;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_fb_reader.sv
// Pipelined framebuffer reader: VGA counters -> packed-pixel word address ->
// external RAM -> pixel field -> palette -> RGB888, one pixel per clock.
module vga_fb_reader
   import vga_fb_reader_pkg::*;
#(
   parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
   parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned BPP         = 1,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned SCALE_SHIFT = 0,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic [VGA_CNT_W-1:0] vga_h_i,
   input  logic [VGA_CNT_W-1:0] vga_v_i,
   output logic [ADDR_W-1:0]    read_address_o,
   output logic                 read_en_o,
   input  logic [WORD_W-1:0]    read_data_i,
   input  logic                 pal_we_i,
   input  logic [BPP-1:0]       pal_addr_i,
   input  logic [RGB_W-1:0]     pal_data_i,
   output logic [31:0]          pixel_number_o,
   output logic [4:0]           pixel_bit_o,
   output logic [RGB_W-1:0]     pixel_out_o,
   output logic                 pixel_valid_o
);

   localparam int unsigned PPW    = WORD_W / BPP;
   localparam int unsigned LINE_W = H_VISIBLE >> SCALE_SHIFT;

   logic              vis_s0;
   logic [31:0]       x_s0;
   logic [31:0]       y_s0;
   logic [31:0]       pn_s0;

   logic              read_en_d,      read_en_q;
   logic [ADDR_W-1:0] read_address_d, read_address_q;
   logic [31:0]       pixel_number_d, pixel_number_q;
   logic [4:0]        pixel_bit_d,    pixel_bit_q;
   logic              pixel_valid_q;

   tap_t              tap_tail;
   logic [BPP-1:0]    pal_idx;

   // Stage 0: source pixel index; invisible samples keep the last address
   always_comb begin
      vis_s0 = (32'(vga_h_i) < H_VISIBLE) && (32'(vga_v_i) < V_VISIBLE);
      x_s0   = 32'(vga_h_i >> SCALE_SHIFT);
      y_s0   = 32'(vga_v_i >> SCALE_SHIFT);
      pn_s0  = y_s0 * LINE_W + x_s0;

      read_en_d      = vis_s0;
      read_address_d = read_address_q;
      pixel_number_d = pixel_number_q;
      pixel_bit_d    = pixel_bit_q;
      if (vis_s0) begin
         read_address_d = ADDR_W'(pn_s0 / PPW);
         pixel_number_d = pn_s0;
         pixel_bit_d    = field_lsb(WORD_W, BPP, pn_s0 % PPW);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         read_en_q      <= 1'b0;
         read_address_q <= '0;
         pixel_number_q <= '0;
         pixel_bit_q    <= '0;
      end else begin
         read_en_q      <= read_en_d;
         read_address_q <= read_address_d;
         pixel_number_q <= pixel_number_d;
         pixel_bit_q    <= pixel_bit_d;
      end
   end

   // Sideband delay matching the RAM read latency
   for (genvar i = 0; i < int'(MEM_LATENCY); i++) begin : g_dly
      tap_t tap_q;
      if (i == 0) begin : g_head
         always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
               tap_q <= '0;
            end else begin
               tap_q <= '{vis: read_en_q, bit_idx: pixel_bit_q};
            end
         end
      end else begin : g_tail
         always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
               tap_q <= '0;
            end else begin
               tap_q <= g_dly[i-1].tap_q;
            end
         end
      end
   end

   assign tap_tail = g_dly[MEM_LATENCY-1].tap_q;
   assign pal_idx  = read_data_i[tap_tail.bit_idx +: BPP];

   vga_fb_reader_palette #(
      .IDX_W (BPP)
   ) u_palette (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .we_i      (pal_we_i),
      .waddr_i   (pal_addr_i),
      .wdata_i   (pal_data_i),
      .rd_en_i   (tap_tail.vis),
      .raddr_i   (pal_idx),
      .rdata_o   (pixel_out_o)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         pixel_valid_q <= 1'b0;
      end else begin
         pixel_valid_q <= tap_tail.vis;
      end
   end

   assign read_en_o      = read_en_q;
   assign read_address_o = read_address_q;
   assign pixel_number_o = pixel_number_q;
   assign pixel_bit_o    = pixel_bit_q;
   assign pixel_valid_o  = pixel_valid_q;

endmodule
